// File: rtl/stim_channel_sequencer_if.sv
// Handshake/config/status bundle between the stimulation config block and the channel sequencer.
// The sequencer uses the slave modport; the configuration side uses master.
interface stim_channel_sequencer_if #(
   parameter int CNT_W = 8
);
   logic             start;
   logic             stop;
   logic             cont;
   logic [7:0]       ch_mask;
   logic [CNT_W-1:0] t_phase;
   logic [CNT_W-1:0] t_gap;
   logic [CNT_W-1:0] t_rest;
   logic [3:0]       ch_code;
   logic             cath;
   logic             anod;
   logic             busy;
   logic             done;

   modport master (
      output start, stop, cont, ch_mask, t_phase, t_gap, t_rest,
      input  ch_code, cath, anod, busy, done
   );

   modport slave (
      input  start, stop, cont, ch_mask, t_phase, t_gap, t_rest,
      output ch_code, cath, anod, busy, done
   );
endinterface

// File: rtl/stim_channel_sequencer.sv
// Biphasic pulse sequencer: walks enabled channels, emits channel code and cathodic/anodic strobes.
// Optional STIM_PULSE_CNT_EN adds a saturating count of completed anodic phases (pulse_count).
module stim_channel_sequencer #(
   parameter int CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   stim_channel_sequencer_if.slave  bus
`ifdef STIM_PULSE_CNT_EN
   ,
   output logic [15:0]              pulse_count
`endif
);

   typedef enum logic [2:0] {
      st_idle,
      st_select,
      st_cath,
      st_gap,
      st_anod,
      st_rest
   } state_t;

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [3:0]       cur, cur_n;
   logic [3:0]       last, last_n;
   logic             stop_l, stop_n;
   logic             stop_eff;

   logic [7:0]       cfg_mask;
   logic             cfg_cont;
   logic [CNT_W-1:0] cfg_phase;
   logic [CNT_W-1:0] cfg_gap;
   logic [CNT_W-1:0] cfg_rest;
   logic [CNT_W-1:0] ph_len;

   logic [3:0]       code_n;
   logic             cath_n, anod_n, busy_n, done_n;
   logic             accept;
   logic             anod_end;

   logic [3:0]       next_above;
   logic [3:0]       first_en;
   logic             found_above;

   assign ph_len   = (cfg_phase == '0) ? ONE : cfg_phase;
   assign stop_eff = stop_l | bus.stop;

   // Next channel above the last served one, plus the lowest enabled channel for wrap-around.
   always_comb begin
      found_above = 1'b0;
      next_above  = '0;
      first_en    = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (cfg_mask[i] && (first_en == '0))
            first_en = 4'(i + 1);
         if (cfg_mask[i] && !found_above && (4'(i + 1) > last)) begin
            found_above = 1'b1;
            next_above  = 4'(i + 1);
         end
      end
   end

   always_comb begin
      state_n  = state;
      cnt_n    = (cnt != '0) ? cnt - ONE : cnt;
      cur_n    = cur;
      last_n   = last;
      stop_n   = stop_l | ((state != st_idle) && bus.stop);
      accept   = 1'b0;
      anod_end = 1'b0;

      case (state)
         st_idle: begin
            if (bus.start) begin
               accept = 1'b1;
               stop_n = 1'b0;
               last_n = '0;
               if (bus.ch_mask != '0)
                  state_n = st_select;
            end
         end
         st_select: begin
            if (stop_eff) begin
               state_n = st_idle;
            end else if (found_above) begin
               cur_n   = next_above;
               cnt_n   = ph_len;
               state_n = st_cath;
            end else if (cfg_cont) begin
               cur_n   = first_en;
               cnt_n   = ph_len;
               state_n = st_cath;
            end else begin
               state_n = st_idle;
            end
         end
         st_cath: begin
            if (cnt == ONE) begin
               if (cfg_gap != '0) begin
                  cnt_n   = cfg_gap;
                  state_n = st_gap;
               end else begin
                  cnt_n   = ph_len;
                  state_n = st_anod;
               end
            end
         end
         st_gap: begin
            if (cnt == ONE) begin
               cnt_n   = ph_len;
               state_n = st_anod;
            end
         end
         st_anod: begin
            // A stop seen in CATH/GAP is held in stop_l and only honoured here, after full charge balance.
            if (cnt == ONE) begin
               anod_end = 1'b1;
               last_n   = cur;
               if (stop_eff) begin
                  state_n = st_idle;
               end else if (cfg_rest != '0) begin
                  cnt_n   = cfg_rest;
                  state_n = st_rest;
               end else begin
                  state_n = st_select;
               end
            end
         end
         st_rest: begin
            if (stop_eff)
               state_n = st_idle;
            else if (cnt == ONE)
               state_n = st_select;
         end
         default: state_n = st_idle;
      endcase

      if (state_n == st_idle)
         stop_n = 1'b0;

      // Outputs are registered, so they are derived from the state being entered.
      busy_n = (state_n != st_idle);
      cath_n = (state_n == st_cath);
      anod_n = (state_n == st_anod);
      code_n = ((state_n == st_cath) || (state_n == st_gap) || (state_n == st_anod)) ? cur_n : '0;
      done_n = (state_n == st_idle) &&
               ((state != st_idle) || (bus.start && (bus.ch_mask == '0)));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= st_idle;
         cnt   <= '0;
         cur   <= '0;
         last  <= '0;
         stop_l <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         cur   <= cur_n;
         last  <= last_n;
         stop_l <= stop_n;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_mask  <= '0;
         cfg_cont  <= 1'b0;
         cfg_phase <= '0;
         cfg_gap   <= '0;
         cfg_rest  <= '0;
      end else if (accept) begin
         cfg_mask  <= bus.ch_mask;
         cfg_cont  <= bus.cont;
         cfg_phase <= bus.t_phase;
         cfg_gap   <= bus.t_gap;
         cfg_rest  <= bus.t_rest;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.ch_code <= '0;
         bus.cath    <= 1'b0;
         bus.anod    <= 1'b0;
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
      end else begin
         bus.ch_code <= code_n;
         bus.cath    <= cath_n;
         bus.anod    <= anod_n;
         bus.busy    <= busy_n;
         bus.done    <= done_n;
      end
   end

`ifdef STIM_PULSE_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pulse_count <= '0;
      else if (accept)
         pulse_count <= '0;
      else if (anod_end && (pulse_count != 16'hFFFF))
         pulse_count <= pulse_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_stim_channel_sequencer.sv
// Self-checking bench for stim_channel_sequencer: trace model built from channel/phase rules,
// per-cycle comparison, directed timelines and randomized sequences.
module tb_stim_channel_sequencer;

   localparam int CNT_W = 8;
   localparam int MAXC  = 2048;
   localparam int L_SEL = 0, L_CATH = 1, L_GAP = 2, L_ANOD = 3, L_REST = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   stim_channel_sequencer_if #(.CNT_W(CNT_W)) bus ();
`ifdef STIM_PULSE_CNT_EN
   logic [15:0] pulse_count;
`endif

   stim_channel_sequencer #(.CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef STIM_PULSE_CNT_EN
      ,
      .pulse_count (pulse_count)
`endif
   );

   int unsigned passed = 0;
   int unsigned total  = 0;

   task automatic check(input string name, input int unsigned got, input int unsigned exp);
      total++;
      if (got == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
   endtask

   // Expected per-cycle outputs; cycle 1 is the first cycle after the start-accepting edge.
   logic [3:0] e_code [MAXC];
   bit         e_cath [MAXC];
   bit         e_anod [MAXC];
   bit         e_busy [MAXC];
   bit         e_done [MAXC];
   int         e_pc   [MAXC];
   int         n_exp;

   logic [3:0] g_code [MAXC];
   bit         g_cath [MAXC];
   bit         g_anod [MAXC];
   bit         g_busy [MAXC];
   bit         g_done [MAXC];
   int         g_pc   [MAXC];

   function automatic int busy_len(input bit [7:0] m, input bit cn, input int tp, input int tg, input int tr);
      int ph;
      ph = (tp == 0) ? 1 : tp;
      if (m == 0) return 0;
      return (cn ? 3 : 1) * $countones(m) * (1 + 2 * ph + tg + tr) + (cn ? 0 : 1);
   endfunction

   function automatic void build(input bit [7:0] m, input bit cn, input int tp, input int tg,
                                 input int tr, input int stop_at);
      int lq[$];
      int cq[$];
      int ph, passes, e, cnt, nb, lab;
      ph = (tp == 0) ? 1 : tp;
      passes = cn ? 3 : 1;
      if (m != 0) begin
         for (int p = 0; p < passes; p++)
            for (int ch = 1; ch <= 8; ch++)
               if (m[ch-1]) begin
                  lq.push_back(L_SEL); cq.push_back(0);
                  for (int k = 0; k < ph; k++) begin lq.push_back(L_CATH); cq.push_back(ch); end
                  for (int k = 0; k < tg; k++) begin lq.push_back(L_GAP);  cq.push_back(ch); end
                  for (int k = 0; k < ph; k++) begin lq.push_back(L_ANOD); cq.push_back(ch); end
                  for (int k = 0; k < tr; k++) begin lq.push_back(L_REST); cq.push_back(0);  end
               end
         if (!cn) begin lq.push_back(L_SEL); cq.push_back(0); end
      end
      nb = lq.size();
      e = nb;
      if (stop_at > 0 && stop_at <= nb) begin
         e = stop_at;
         if (lq[stop_at-1] != L_SEL && lq[stop_at-1] != L_REST)
            while (e < nb && lq[e] != L_SEL && lq[e] != L_REST) e++;
      end
      n_exp = e + 4;
      cnt = 0;
      for (int c = 1; c <= n_exp; c++) begin
         e_pc[c] = cnt;
         if (c <= e) begin
            lab = lq[c-1];
            e_code[c] = (lab == L_CATH || lab == L_GAP || lab == L_ANOD) ? 4'(cq[c-1]) : 4'd0;
            e_cath[c] = (lab == L_CATH);
            e_anod[c] = (lab == L_ANOD);
            e_busy[c] = 1'b1;
            e_done[c] = 1'b0;
            if (lab == L_ANOD && (c == e || lq[c] != L_ANOD)) cnt++;
         end else begin
            e_code[c] = 4'd0;
            e_cath[c] = 1'b0;
            e_anod[c] = 1'b0;
            e_busy[c] = 1'b0;
            e_done[c] = (c == e + 1);
         end
      end
   endfunction

   bit active = 1'b0;
   int cyc = 0;

   always @(negedge clk) begin
      if (active) begin
         check($sformatf("c%0d ch_code", cyc), bus.ch_code, e_code[cyc]);
         check($sformatf("c%0d cath", cyc), bus.cath, e_cath[cyc]);
         check($sformatf("c%0d anod", cyc), bus.anod, e_anod[cyc]);
         check($sformatf("c%0d busy", cyc), bus.busy, e_busy[cyc]);
         check($sformatf("c%0d done", cyc), bus.done, e_done[cyc]);
         g_code[cyc] = bus.ch_code;
         g_cath[cyc] = bus.cath;
         g_anod[cyc] = bus.anod;
         g_busy[cyc] = bus.busy;
         g_done[cyc] = bus.done;
`ifdef STIM_PULSE_CNT_EN
         check($sformatf("c%0d pulse_count", cyc), pulse_count, e_pc[cyc]);
         g_pc[cyc] = pulse_count;
`else
         g_pc[cyc] = 0;
`endif
         cyc++;
         if (cyc > n_exp) active = 1'b0;
      end
   end

   // Entered and left at posedge+#1.
   task automatic run_seq(input bit [7:0] m, input bit cn, input int tp, input int tg, input int tr,
                          input int stop_at, input bit stop_with_start, input bit noise);
      build(m, cn, tp, tg, tr, stop_at);
      bus.ch_mask = m;
      bus.cont    = cn;
      bus.t_phase = CNT_W'(tp);
      bus.t_gap   = CNT_W'(tg);
      bus.t_rest  = CNT_W'(tr);
      bus.start   = 1'b1;
      bus.stop    = stop_with_start;
      @(posedge clk); #1;
      cyc = 1;
      active = 1'b1;
      for (int c = 1; c <= n_exp; c++) begin
         bus.start = noise && e_busy[c] && ($urandom_range(0, 5) == 0);
         bus.stop  = (c == stop_at) || (noise && !e_busy[c] && ($urandom_range(0, 3) == 0));
         if (noise) begin
            bus.ch_mask = 8'($urandom);
            bus.cont    = 1'($urandom);
            bus.t_phase = CNT_W'($urandom);
            bus.t_gap   = CNT_W'($urandom);
            bus.t_rest  = CNT_W'($urandom);
         end
         @(posedge clk); #1;
      end
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      for (int w = 0; w < 4 && active; w++) @(posedge clk);
      if (active) begin
         check("compare window closed", 0, 1);
         active = 1'b0;
      end
      #1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit [7:0] m;
      bit       cn;
      int       tp, tg, tr, nb, sa;

      bus.start = 0; bus.stop = 0; bus.cont = 0; bus.ch_mask = '0;
      bus.t_phase = '0; bus.t_gap = '0; bus.t_rest = '0;
      @(posedge clk); #1;
      check("reset ch_code", bus.ch_code, 0);
      check("reset cath", bus.cath, 0);
      check("reset anod", bus.anod, 0);
      check("reset busy", bus.busy, 0);
      check("reset done", bus.done, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Single round, mask 00000101, 3/2/4.
      run_seq(8'b0000_0101, 0, 3, 2, 4, 0, 0, 0);
      check("t1 select c1 busy", g_busy[1], 1);
      check("t1 select c1 code", g_code[1], 0);
      check("t1 c2 code", g_code[2], 1);
      check("t1 c4 cath", g_cath[4], 1);
      check("t1 c5 cath", g_cath[5], 0);
      check("t1 c7 anod", g_anod[7], 1);
      check("t1 c9 anod", g_anod[9], 1);
      check("t1 c10 code", g_code[10], 0);
      check("t1 c15 code", g_code[15], 3);
      check("t1 c22 anod", g_anod[22], 1);
      check("t1 c27 busy", g_busy[27], 1);
      check("t1 c28 done", g_done[28], 1);
      check("t1 c28 busy", g_busy[28], 0);

      // Zero timings on channel 8.
      run_seq(8'b1000_0000, 0, 0, 0, 0, 0, 0, 0);
      check("t2 c2 code", g_code[2], 8);
      check("t2 c2 cath", g_cath[2], 1);
      check("t2 c3 anod", g_anod[3], 1);
      check("t2 c4 code", g_code[4], 0);
      check("t2 c5 done", g_done[5], 1);

      // Continuous wrap 1,8,1 with stop in second channel-1 CATH.
      run_seq(8'b1000_0001, 1, 3, 1, 2, 23, 0, 0);
      check("t3 c12 code", g_code[12], 8);
      check("t3 c22 code", g_code[22], 1);
      check("t3 c28 anod", g_anod[28], 1);
      check("t3 c29 done", g_done[29], 1);
      check("t3 c29 busy", g_busy[29], 0);

      // Empty mask, with a simultaneous stop.
      run_seq(8'h00, 0, 2, 1, 1, 0, 1, 0);
      check("t4 c1 done", g_done[1], 1);
      check("t4 c1 busy", g_busy[1], 0);
      check("t4 c2 done", g_done[2], 0);

      // All channels, minimal timings.
      run_seq(8'hFF, 0, 1, 0, 0, 0, 0, 0);
      check("t5 c26 done", g_done[26], 1);
`ifdef STIM_PULSE_CNT_EN
      check("t5 pulse_count at done", g_pc[26], 8);
      run_seq(8'h01, 0, 1, 0, 0, 0, 0, 0);
      check("t5 pulse_count cleared", g_pc[1], 0);
`endif

      // Asynchronous reset during CATH.
      bus.ch_mask = 8'b0000_0101; bus.cont = 0;
      bus.t_phase = CNT_W'(3); bus.t_gap = CNT_W'(2); bus.t_rest = CNT_W'(4);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #3;
      check("pre-reset cath", bus.cath, 1);
      rst_n = 1'b0;
      #1;
      check("async reset ch_code", bus.ch_code, 0);
      check("async reset cath", bus.cath, 0);
      check("async reset busy", bus.busy, 0);
      @(posedge clk); #4;
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("post-reset idle busy %0d", k), bus.busy, 0);
         check($sformatf("post-reset idle cath %0d", k), bus.cath, 0);
         check($sformatf("post-reset idle done %0d", k), bus.done, 0);
      end
      @(posedge clk); #1;

      // Randomized sequences with input noise while busy.
      for (int it = 0; it < 40; it++) begin
         m  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
         cn = ($urandom_range(0, 2) == 0);
         tp = $urandom_range(0, 4);
         tg = $urandom_range(0, 2);
         tr = $urandom_range(0, 2);
         nb = busy_len(m, cn, tp, tg, tr);
         if (nb == 0) sa = 0;
         else if (cn || $urandom_range(0, 2) == 0) sa = $urandom_range(1, nb);
         else sa = 0;
         run_seq(m, cn, tp, tg, tr, sa, 1'($urandom), 1);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
